apb3_cmd_initiator: RTL and testbench

APB3 requester that turns a simple valid/ready command stream into single APB3 transfers. It drives the master side of the APB3 interconnect (PADDR/PSEL/PENABLE/PWRITE/PWDATA) and collects PRDATA/PREADY/PSLVERR. It returns one response per command on a valid/ready response stream. A wait-state timeout protects against hung slaves. Used by bring-up and debug logic that needs APB access without the processor.

---
 rtl/apb3_cmd_initiator.sv | 142 ++++++++++++++
 tb/tb_apb3_cmd_initiator.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb3_cmd_initiator.sv
// apb3_cmd_initiator
// Turns a valid/ready command stream into single APB3 transfers and returns
// one response per command on a valid/ready response stream. A wait-state
// timeout aborts transfers to slaves that never assert PREADY.
//
// Ports:
//   PCLK, PRESETN                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           command handshake (accepted only in IDLE)
//   cmd_write/cmd_addr/cmd_wdata  command payload
//   rsp_valid/rsp_ready           response handshake
//   rsp_rdata/rsp_err/rsp_timeout response payload
//   PADDR/PSEL/PENABLE/PWRITE/PWDATA  APB3 requester outputs
//   PRDATA/PREADY/PSLVERR             APB3 completer inputs
module apb3_cmd_initiator #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TO_WIDTH       = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETN,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Word-aligned APB addresses: the two low byte-address bits are cleared.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
  localparam logic [TO_WIDTH-1:0]   TO_LIMIT   = TO_WIDTH'(TIMEOUT_CYCLES);
  localparam bit                    TO_EN      = (TIMEOUT_CYCLES != 0);

  state_t              state_r;
  logic [TO_WIDTH-1:0] wait_cnt_r;
  logic [TO_WIDTH-1:0] wait_cnt_inc_s;

  // Value the wait counter takes after one more PREADY-low ACCESS cycle.
  assign wait_cnt_inc_s = wait_cnt_r + {{(TO_WIDTH-1){1'b0}}, 1'b1};

  // Transfer sequencer: state, APB outputs and response registers.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_r     <= IDLE;
      wait_cnt_r  <= {TO_WIDTH{1'b0}};
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= {DATA_WIDTH{1'b0}};
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      PADDR       <= {ADDR_WIDTH{1'b0}};
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PWDATA      <= {DATA_WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          // cmd_ready is registered, so acceptance is gated on its current value.
          if (cmd_valid && cmd_ready) begin
            PADDR     <= cmd_addr & ALIGN_MASK;
            PWDATA    <= cmd_wdata;
            PWRITE    <= cmd_write;
            PSEL      <= 1'b1;
            PENABLE   <= 1'b0;
            cmd_ready <= 1'b0;
            state_r   <= SETUP;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state_r <= ACCESS;
        end
        ACCESS: begin
          // PREADY has priority over a timeout landing in the same cycle.
          if (PREADY) begin
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= (!PWRITE && !PSLVERR) ? PRDATA : {DATA_WIDTH{1'b0}};
            state_r     <= RESP;
          end else if (TO_EN && (wait_cnt_inc_s == TO_LIMIT)) begin
            wait_cnt_r  <= wait_cnt_inc_s;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= {DATA_WIDTH{1'b0}};
            state_r     <= RESP;
          end else begin
            wait_cnt_r <= wait_cnt_inc_s;
          end
        end
        RESP: begin
          // cmd_ready rises together with the return to IDLE so the next
          // command can be taken in the very first IDLE cycle.
          if (rsp_ready) begin
            rsp_valid  <= 1'b0;
            wait_cnt_r <= {TO_WIDTH{1'b0}};
            cmd_ready  <= 1'b1;
            state_r    <= IDLE;
          end else begin
            rsp_valid <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          PSEL      <= 1'b0;
          PENABLE   <= 1'b0;
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb3_cmd_initiator.sv
// Self-checking bench for apb3_cmd_initiator. Expected responses are pushed
// to a scoreboard queue when a command is issued and compared when the DUT
// completes a response handshake. A second instance with the timeout disabled
// checks that a hung slave is waited on indefinitely.
module tb_apb3_cmd_initiator;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
  localparam logic [31:0] BUSY_ADDR = 32'h7000_3008;
  localparam logic [31:0] BUSY_DATA = 32'hCAFE_F00D;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } rsp_t;

  logic          PCLK = 1'b0;
  logic          PRESETN = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid, rsp_ready = 1'b0, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] PADDR;
  logic          PSEL, PENABLE, PWRITE;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA = '0;
  logic          PREADY = 1'b0, PSLVERR = 1'b0;

  // Timeout-disabled instance
  logic          cmd_valid_d = 1'b0, cmd_ready_d;
  logic          rsp_valid_d, rsp_err_d, rsp_timeout_d;
  logic [DW-1:0] rsp_rdata_d, pwdata_d;
  logic [AW-1:0] paddr_d;
  logic          psel_d, penable_d, pwrite_d;

  int   n_tests = 0;
  int   n_fail  = 0;
  rsp_t exp_q[$];
  rsp_t mon_e;

  always #5 PCLK = ~PCLK;

  apb3_cmd_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .TO_WIDTH(16)) dut (
    .PCLK(PCLK), .PRESETN(PRESETN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  apb3_cmd_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(0), .TO_WIDTH(16)) dut_noto (
    .PCLK(PCLK), .PRESETN(PRESETN),
    .cmd_valid(cmd_valid_d), .cmd_ready(cmd_ready_d), .cmd_write(1'b0),
    .cmd_addr(32'h7000_5000), .cmd_wdata(32'h0000_0000),
    .rsp_valid(rsp_valid_d), .rsp_ready(1'b1), .rsp_rdata(rsp_rdata_d),
    .rsp_err(rsp_err_d), .rsp_timeout(rsp_timeout_d),
    .PADDR(paddr_d), .PSEL(psel_d), .PENABLE(penable_d), .PWRITE(pwrite_d), .PWDATA(pwdata_d),
    .PRDATA(32'h0000_0000), .PREADY(1'b0), .PSLVERR(1'b0)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Scoreboard: compare each completed response handshake with the oldest expectation.
  always @(negedge PCLK) begin
    if (PRESETN && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check_val("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_val("rsp_rdata", rsp_rdata, mon_e.rdata);
        check_val("rsp_err", rsp_err, mon_e.err);
        check_val("rsp_timeout", rsp_timeout, mon_e.to);
      end
    end
  end

  task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int waits, input logic serr, input logic [31:0] rdata,
                         input logic exp_to, input int stall, input logic busy);
    rsp_t e;
    int   n;
    int   acc;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    check_val("cmd_ready_wait", cmd_ready, 1);
    e.to    = exp_to;
    e.err   = exp_to | serr;
    e.rdata = (exp_to || serr || wr) ? 32'h0 : rdata;
    exp_q.push_back(e);
    tick();
    cmd_valid = 1'b0;
    check_val("setup_psel_pen", {PSEL, PENABLE}, 2'b10);
    check_val("setup_paddr", PADDR, addr & 32'hFFFF_FFFC);
    check_val("setup_pwrite", PWRITE, wr);
    if (wr) check_val("setup_pwdata", PWDATA, wdata);
    PREADY = 1'b0;
    tick();
    acc = 0;
    while (PENABLE && acc < 50) begin
      check_val("access_psel", PSEL, 1);
      check_val("access_paddr", PADDR, addr & 32'hFFFF_FFFC);
      PREADY  = (acc >= waits);
      PSLVERR = serr;
      PRDATA  = rdata;
      tick();
      acc++;
    end
    PREADY  = 1'b0;
    PSLVERR = 1'b1;
    PRDATA  = $urandom;
    check_val("access_cycles", acc, exp_to ? TO : waits + 1);
    check_val("resp_bus_idle", {PSEL, PENABLE}, 2'b00);
    for (int s = 0; s < stall; s++) begin
      check_val("hold_valid", rsp_valid, 1);
      check_val("hold_cmd_ready", cmd_ready, 0);
      check_val("hold_rdata", rsp_rdata, e.rdata);
      check_val("hold_err", {rsp_err, rsp_timeout}, {e.err, e.to});
      if (busy) begin
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = BUSY_ADDR;
        cmd_wdata = BUSY_DATA;
      end
      tick();
      if (busy) check_val("busy_no_start", PSEL, 0);
    end
    PSLVERR = 1'b0;
    check_val("resp_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_val("post_hs_valid", rsp_valid, 0);
    check_val("post_hs_cmd_ready", cmd_ready, 1);
  endtask

  initial begin
    int n;
    #3;
    check_val("reset_outputs", {cmd_ready, rsp_valid, PSEL, PENABLE, PWRITE}, 5'b0);
    check_val("reset_paddr", PADDR, 32'h0);
    repeat (2) @(posedge PCLK);
    #1;
    PRESETN = 1'b1;
    tick();
    check_val("idle_cmd_ready", cmd_ready, 1);

    run_cmd(1'b1, 32'h7000_1004, 32'hDEAD_BEEF, 0, 1'b0, 32'h5555_5555, 1'b0, 0, 1'b0);
    run_cmd(1'b0, 32'h7000_2003, 32'h0, 3, 1'b0, 32'h1234_5678, 1'b0, 0, 1'b0);
    run_cmd(1'b0, 32'h7000_2010, 32'h0, 1, 1'b1, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
    run_cmd(1'b0, 32'h7000_2020, 32'h0, 1000, 1'b0, 32'hAAAA_AAAA, 1'b1, 0, 1'b0);
    // PREADY arrives in the cycle the counter would hit its limit
    run_cmd(1'b0, 32'h7000_2024, 32'h0, TO - 1, 1'b0, 32'h0BAD_F00D, 1'b0, 0, 1'b0);
    run_cmd(1'b0, 32'h7000_2028, 32'h0, 2, 1'b0, 32'h8765_4321, 1'b0, 5, 1'b1);
    run_cmd(1'b1, BUSY_ADDR, BUSY_DATA, 0, 1'b0, 32'h0, 1'b0, 0, 1'b0);

    // Timeout disabled: slave never ready, transfer must still be pending.
    cmd_valid_d = 1'b1;
    n = 0;
    while (!cmd_ready_d && n < 20) begin
      tick();
      n++;
    end
    tick();
    cmd_valid_d = 1'b0;
    repeat (1000) tick();
    check_val("noto_still_access", {psel_d, penable_d}, 2'b11);
    check_val("noto_no_rsp", rsp_valid_d, 0);

    // Reset during ACCESS wait states.
    cmd_write = 1'b0;
    cmd_addr  = 32'h7000_4000;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    tick();
    cmd_valid = 1'b0;
    PREADY = 1'b0;
    repeat (3) tick();
    check_val("pre_reset_access", {PSEL, PENABLE}, 2'b11);
    PRESETN = 1'b0;
    #1;
    check_val("async_reset_drop", {PSEL, PENABLE, rsp_valid}, 3'b000);
    check_val("async_reset_noto", {psel_d, penable_d}, 2'b00);
    tick();
    PRESETN = 1'b1;
    repeat (3) tick();
    check_val("no_rsp_after_reset", rsp_valid, 0);
    check_val("queue_empty", exp_q.size(), 0);
    run_cmd(1'b0, 32'h7000_4004, 32'h0, 1, 1'b0, 32'h0F0F_1234, 1'b0, 0, 1'b0);
    check_val("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
